// File: rtl/i2c_nios_irq_collector.sv
// Interrupt collector for a Nios: latches edge/level sources, masks and aggregates them, counts timer ticks.
// Avalon-MM slave with single-cycle registered reads; no backpressure, writes always accepted.
module i2c_nios_irq_collector #(
    parameter int NUM_SRC  = 8,
    parameter int TICK_SRC = 0,
    parameter int TICK_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] irq_d_q;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               en_q, en_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;

    logic               wr;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] wd_src;
    logic               tick_rise;
    logic               ovf_set;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_src    = writedata[NUM_SRC-1:0];
    assign unused_wd = ^writedata;
    assign rise      = irq_in & ~irq_d_q;
    assign set       = (edge_q & rise) | (~edge_q & irq_in);
    assign tick_rise = rise[TICK_SRC];

    // Set is OR-ed in after the clear so a same-cycle event survives the W1C.
    assign pending_d = (pending_q & ~((wr && address == 3'd0) ? wd_src : '0)) | set;
    assign mask_d    = (wr && address == 3'd1) ? wd_src : mask_q;
    assign edge_d    = (wr && address == 3'd4) ? wd_src : edge_q;
    assign en_d      = (wr && address == 3'd5) ? writedata[0] : en_q;
    assign ovf_d     = ovf_set | (ovf_q & ~(wr && address == 3'd5 && writedata[1]));
    assign irq_d     = en_q & (|(pending_q & mask_q));

    always_comb begin
        tick_d  = tick_q;
        ovf_set = 1'b0;
        if (wr && address == 3'd3) begin
            tick_d = tick_rise ? {{(TICK_W-1){1'b0}}, 1'b1} : '0;
        end else if (tick_rise) begin
            if (&tick_q) ovf_set = 1'b1;
            else         tick_d  = tick_q + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        rdata_d = 16'h0000;
        case (address)
            3'd0:    rdata_d = 16'(pending_q);
            3'd1:    rdata_d = 16'(mask_q);
            3'd2:    rdata_d = 16'(pending_q & mask_q);
            3'd3:    rdata_d = 16'(tick_q);
            3'd4:    rdata_d = 16'(edge_q);
            3'd5:    rdata_d = {14'h0000, ovf_q, en_q};
            default: rdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '1;
            irq_d_q   <= '0;
            tick_q    <= '0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            irq_d_q   <= irq_in;
            tick_q    <= tick_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: doc/i2c_nios_irq_collector.md
I2C_NIOS_IRQ_COLLECTOR -- requirements
Module: i2c_nios_irq_collector

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, giving the number of interrupt sources (legal range 1..16).
REQ-002 The block SHALL have parameter TICK_SRC, default 0, giving the irq_in index whose rising edges are counted (timer irq).
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write, active-low.
REQ-008 writedata  input  16  Avalon-MM write data.
REQ-009 readdata  output  16  Avalon-MM read data, registered.
REQ-010 irq_in  input  NUM_SRC  interrupt request inputs, bit TICK_SRC driven by the timer irq.
REQ-011 irq  output  1  aggregated interrupt to the Nios, registered.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; wr(n) below means a write with address=n.
REQ-013 Register map: 0 PENDING (read; write-1-to-clear), 1 MASK (RW), 2 ACTIVE = PENDING & MASK (read-only), 3 TICK_COUNT (read; any write clears), 4 EDGE_MODE (RW), 5 CONTROL (RW), 6-7 read as 0, and writes to them SHALL be ignored.
REQ-014 Bits above NUM_SRC-1 in PENDING, MASK, ACTIVE and EDGE_MODE SHALL read 0 and ignore writes.
REQ-015 A one-cycle-delayed copy irq_d of irq_in SHALL be kept; rise[i] = irq_in[i] & ~irq_d[i].
REQ-016 Set condition: set[i] = rise[i] when EDGE_MODE[i]=1, or irq_in[i] when EDGE_MODE[i]=0 (level).
REQ-017 PENDING[i] SHALL be cleared by wr(0) with writedata[i]=1 and set by set[i]; when both occur in the same cycle, the set SHALL win.
REQ-018 PENDING SHALL be updated independently of MASK and CONTROL.EN (masked sources still latch).
REQ-019 TICK_COUNT SHALL increment by 1 on each rise[TICK_SRC], independent of EDGE_MODE and MASK.
REQ-020 TICK_COUNT SHALL saturate at 0xFFFF; an increment attempted at 0xFFFF SHALL set CONTROL.OVF (bit 1) and leave the count at 0xFFFF.
REQ-021 wr(3) SHALL clear TICK_COUNT; a simultaneous rise[TICK_SRC] SHALL leave TICK_COUNT = 1.
REQ-022 CONTROL bit 0 EN SHALL be read/write; bit 1 OVF SHALL be cleared by wr(5) with writedata[1]=1, and a simultaneous overflow SHALL win; bits 15:2 SHALL read 0.
REQ-023 irq SHALL be registered as EN & |(PENDING & MASK), computed from the current-cycle register values, so it follows the enabling event by one cycle.
REQ-024 readdata SHALL be registered every cycle from the address-selected register regardless of chipselect (read latency 1).
REQ-025 A register written in cycle N SHALL appear on readdata when address is held and sampled in cycle N+2.

Reset
REQ-026 When reset_n=0 at a clk edge: PENDING=0, MASK=0, EDGE_MODE=all ones (edge mode), CONTROL=0, TICK_COUNT=0, irq_d=0, readdata=0, irq=0.
REQ-027 Reset SHALL override any simultaneous write or input event.
REQ-028 Because irq_d resets to 0, an irq_in bit high during and after reset SHALL produce one rise in the first cycle after reset.

Verification
REQ-029 Edge latch: MASK=0x01, EN=1, pulse irq_in[0] for 3 cycles -> PENDING=0x01, TICK_COUNT=1, irq=1 one cycle after PENDING sets.
REQ-030 W1C vs set: with PENDING=0x03, wr(0) 0x03 in the same cycle as a rise on irq_in[1] -> PENDING=0x02.
REQ-031 Level mode: EDGE_MODE=0xFE, irq_in[0] held high, wr(0) 0x01 -> PENDING[0] reads 1 again on the next read.
REQ-032 Saturation: 65536 rises on irq_in[0] -> TICK_COUNT=0xFFFF and CONTROL=0x0002 with EN=0; wr(5) 0x0002 -> CONTROL=0x0000.
REQ-033 Masking and enable: PENDING=0x80, MASK=0x7F -> irq=0; set MASK=0xFF with EN=0 -> irq=0; set EN=1 -> irq=1.
REQ-034 Mid-operation reset: reset_n=0 for one cycle while irq=1 and TICK_COUNT=5 -> all registers at reset values, irq=0, readdata=0.
